// File: rtl/mcp_regfile_wb_if.sv
// Bus between the multicycle controller/datapath and the register file.
// Carries IR, writeback controls and data, A/B operands and the debug read port.
interface mcp_regfile_wb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [DATA_W-1:0] instr_i32;
    logic              enable_wrf_i;
    logic              reg_dst_rtrd_i;
    logic              mem_to_reg_i;
    logic [DATA_W-1:0] alu_out_i32;
    logic [DATA_W-1:0] data_i32;
    logic [DATA_W-1:0] a_o32;
    logic [DATA_W-1:0] b_o32;
    logic [ADDR_W-1:0] dbg_addr_i5;
    logic [DATA_W-1:0] dbg_data_o32;

    modport master (
        output instr_i32, enable_wrf_i, reg_dst_rtrd_i, mem_to_reg_i,
        output alu_out_i32, data_i32, dbg_addr_i5,
        input  a_o32, b_o32, dbg_data_o32
    );

    modport slave (
        input  instr_i32, enable_wrf_i, reg_dst_rtrd_i, mem_to_reg_i,
        input  alu_out_i32, data_i32, dbg_addr_i5,
        output a_o32, b_o32, dbg_data_o32
    );
endinterface

// File: rtl/mcp_regfile_wb.sv
// Register file + writeback stage of the multicycle datapath.
// Ports: clk_i, reset_i (sync, active high), bus (mcp_regfile_wb_if.slave):
//   IR, RegWrite/RegDst/MemtoReg, ALUOut/Data in; A/B operands and debug read out.
// Optional macro RF_WRITE_BYPASS_EN: forward same-edge writeback data into A/B.
module mcp_regfile_wb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic             clk_i,
    input  logic             reset_i,
    mcp_regfile_wb_if.slave  bus
);
    localparam int NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;

    logic [ADDR_W-1:0] rs, rt, rd, wa;
    logic [DATA_W-1:0] wd, rd1, rd2;
    logic              wr_hit;

    // IR fields outside rs/rt/rd are of no interest here.
    logic unused_instr;
    assign unused_instr = ^{bus.instr_i32[DATA_W-1:26], bus.instr_i32[10:0]};

    assign rs = bus.instr_i32[25:21];
    assign rt = bus.instr_i32[20:16];
    assign rd = bus.instr_i32[15:11];

    assign wa     = bus.reg_dst_rtrd_i ? rd : rt;
    assign wd     = bus.mem_to_reg_i ? bus.data_i32 : bus.alu_out_i32;
    assign wr_hit = bus.enable_wrf_i && (wa != '0);

    assign rd1 = (rs == '0) ? '0 : regs_q[rs];
    assign rd2 = (rt == '0) ? '0 : regs_q[rt];

    always_comb begin
        regs_d = regs_q;
        if (wr_hit) begin
            regs_d[wa] = wd;
        end
        regs_d[0] = '0;
    end

    always_comb begin
        a_d = rd1;
        b_d = rd2;
`ifdef RF_WRITE_BYPASS_EN
        // wr_hit already excludes r0, so r0 is never forwarded.
        if (wr_hit && (wa == rs)) begin
            a_d = wd;
        end
        if (wr_hit && (wa == rt)) begin
            b_d = wd;
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            regs_q <= '{default: '0};
            a_q    <= '0;
            b_q    <= '0;
        end else begin
            regs_q <= regs_d;
            a_q    <= a_d;
            b_q    <= b_d;
        end
    end

    assign bus.a_o32        = a_q;
    assign bus.b_o32        = b_q;
    // Debug read sees committed state only; no forwarding.
    assign bus.dbg_data_o32 = (bus.dbg_addr_i5 == '0) ? '0
                                                      : regs_q[bus.dbg_addr_i5];
endmodule

// File: tb/tb_mcp_regfile_wb.sv
// Directed self-checking bench for mcp_regfile_wb.
// Honours RF_WRITE_BYPASS_EN for collision expectations.
module tb_mcp_regfile_wb;
    logic clk = 1'b0;
    logic rst;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mcp_regfile_wb_if #(.DATA_W(32), .ADDR_W(5)) rf_if ();

    mcp_regfile_wb #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (rf_if.slave)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_dbg(input string tag, input logic [4:0] a,
                           input logic [31:0] exp);
        rf_if.dbg_addr_i5 = a;
        #1;
        check(tag, rf_if.dbg_data_o32, exp);
    endtask

    function automatic logic [31:0] ir(input logic [4:0] rs,
                                       input logic [4:0] rt,
                                       input logic [4:0] rd);
        ir = {6'd0, rs, rt, rd, 11'd0};
    endfunction

    initial begin
        rst                  = 1'b1;
        rf_if.instr_i32      = '0;
        rf_if.enable_wrf_i   = 1'b0;
        rf_if.reg_dst_rtrd_i = 1'b0;
        rf_if.mem_to_reg_i   = 1'b0;
        rf_if.alu_out_i32    = '0;
        rf_if.data_i32       = '0;
        rf_if.dbg_addr_i5    = '0;
        step();
        step();
        rst = 1'b0;
        check("rst_a", rf_if.a_o32, 32'h0);
        check("rst_b", rf_if.b_o32, 32'h0);
        chk_dbg("rst_r5", 5'd5, 32'h0);

        // RegDst / MemtoReg steering
        rf_if.instr_i32      = ir(5'd0, 5'd5, 5'd9);
        rf_if.alu_out_i32    = 32'h1234;
        rf_if.data_i32       = 32'hBEEF;
        rf_if.enable_wrf_i   = 1'b1;
        rf_if.reg_dst_rtrd_i = 1'b1;
        rf_if.mem_to_reg_i   = 1'b0;
        step();
        chk_dbg("steer_r9", 5'd9, 32'h1234);
        chk_dbg("steer_r5_untouched", 5'd5, 32'h0);
        rf_if.reg_dst_rtrd_i = 1'b0;
        rf_if.mem_to_reg_i   = 1'b1;
        step();
        chk_dbg("steer_r5", 5'd5, 32'hBEEF);

        // r0 protection
        rf_if.instr_i32      = ir(5'd0, 5'd0, 5'd0);
        rf_if.mem_to_reg_i   = 1'b0;
        rf_if.alu_out_i32    = 32'hFFFF_FFFF;
        step();
        chk_dbg("r0_dbg", 5'd0, 32'h0);
        check("r0_a", rf_if.a_o32, 32'h0);
        check("r0_b", rf_if.b_o32, 32'h0);

        // Preload r3=7, r4=8 (rs=0 throughout)
        rf_if.instr_i32   = ir(5'd0, 5'd3, 5'd0);
        rf_if.alu_out_i32 = 32'd7;
        step();
        rf_if.instr_i32   = ir(5'd0, 5'd4, 5'd0);
        rf_if.alu_out_i32 = 32'd8;
        step();
        rf_if.enable_wrf_i = 1'b0;
        chk_dbg("pre_r3", 5'd3, 32'd7);
        chk_dbg("pre_r4", 5'd4, 32'd8);

        // A/B latency: one edge after IR change
        rf_if.instr_i32 = ir(5'd3, 5'd4, 5'd0);
        #1;
        check("lat_a_before", rf_if.a_o32, 32'h0);
        step();
        check("lat_a", rf_if.a_o32, 32'd7);
        check("lat_b", rf_if.b_o32, 32'd8);

        // Collision: write r3 via rd while rs=3
        rf_if.instr_i32      = ir(5'd3, 5'd4, 5'd3);
        rf_if.reg_dst_rtrd_i = 1'b1;
        rf_if.alu_out_i32    = 32'h55;
        rf_if.enable_wrf_i   = 1'b1;
        step();
        rf_if.enable_wrf_i   = 1'b0;
`ifdef RF_WRITE_BYPASS_EN
        check("coll_a", rf_if.a_o32, 32'h55);
`else
        check("coll_a", rf_if.a_o32, 32'd7);
`endif
        check("coll_b", rf_if.b_o32, 32'd8);
        step();
        check("coll_a_next", rf_if.a_o32, 32'h55);
        chk_dbg("coll_r3", 5'd3, 32'h55);

        // Held write to r10 with changing data
        rf_if.instr_i32      = ir(5'd0, 5'd0, 5'd10);
        rf_if.reg_dst_rtrd_i = 1'b1;
        rf_if.enable_wrf_i   = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            rf_if.alu_out_i32 = 32'(i);
            step();
            chk_dbg($sformatf("held_r10_%0d", i), 5'd10, 32'(i));
        end
        rf_if.enable_wrf_i = 1'b0;
        chk_dbg("held_r9", 5'd9, 32'h1234);
        chk_dbg("held_r5", 5'd5, 32'hBEEF);
        chk_dbg("held_r3", 5'd3, 32'h55);
        chk_dbg("held_r4", 5'd4, 32'd8);
        chk_dbg("held_r11", 5'd11, 32'h0);

        // Reset overrides a same-edge write
        rf_if.instr_i32      = ir(5'd3, 5'd4, 5'd11);
        step();
        check("prerst_a", rf_if.a_o32, 32'h55);
        rst                  = 1'b1;
        rf_if.enable_wrf_i   = 1'b1;
        rf_if.alu_out_i32    = 32'h77;
        step();
        rst                  = 1'b0;
        rf_if.enable_wrf_i   = 1'b0;
        check("rst2_a", rf_if.a_o32, 32'h0);
        check("rst2_b", rf_if.b_o32, 32'h0);
        chk_dbg("rst2_r11", 5'd11, 32'h0);
        chk_dbg("rst2_r9", 5'd9, 32'h0);
        chk_dbg("rst2_r3", 5'd3, 32'h0);
        chk_dbg("rst2_r10", 5'd10, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
